// File: rtl/bshift_pipe_if.sv
// Operand-issue / result-return handshake bundle for the pipelined barrel shifter.
interface bshift_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic             rotate;
    logic             left;
    logic             arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             ov;
    logic             z;
    logic             c;

    modport master (
        output in_valid, a, b, rotate, left, arith, out_ready,
        input  in_ready, out_valid, q, ov, z, c
    );

    modport slave (
        input  in_valid, a, b, rotate, left, arith, out_ready,
        output in_ready, out_valid, q, ov, z, c
    );
endinterface

// File: rtl/bshift_pipe.sv
// Three-stage barrel shifter: left ops are bit-reversed around a shared right rotator,
// then masked/filled; valid/ready flow control with collapsing bubbles.
module bshift_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    bshift_pipe_if.slave bus
);
    localparam int unsigned     LO   = SHW / 2;
    localparam logic [WIDTH-1:0] ONES = '1;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) r[i] = x[int'(WIDTH) - 1 - i];
        return r;
    endfunction

    // Right-rotate through the mux levels top..bot only.
    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] x,
                                                   input logic [SHW-1:0]   amt,
                                                   input int               top,
                                                   input int               bot);
        logic [WIDTH-1:0] t;
        t = x;
        for (int k = int'(SHW) - 1; k >= 0; k--) begin
            if (k <= top && k >= bot && amt[k])
                t = (t >> (1 << k)) | (t << (int'(WIDTH) - (1 << k)));
        end
        return t;
    endfunction

    logic             v1, v2, v3;
    logic             adv1, adv2, adv3;
    logic             in_rdy;

    logic [WIDTH-1:0] x1, m1, x2, m2;
    logic [SHW-1:0]   amt1, amt2;
    logic             rot1, left1, sla1, fill1, msb1;
    logic             rot2, left2, sla2, fill2, msb2;

    logic [WIDTH-1:0] q_r;
    logic             ov_r, z_r, c_r;

    logic [WIDTH-1:0] s1_x, s1_mask, s2_x, s3_r, s3_sh, s3_res;
    logic             s1_fill, s1_sla, s3_ov, s3_c, s3_z;

    assign adv3   = bus.out_ready;
    assign adv2   = !v3 || adv3;
    assign adv1   = !v2 || adv2;
    assign in_rdy = !v1 || adv1;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = v3;
    assign bus.q         = q_r;
    assign bus.ov        = ov_r;
    assign bus.z         = z_r;
    assign bus.c         = c_r;

    // S1: reverse for left ops; mask marks the top b positions of the rotated word.
    always_comb begin
        s1_x    = bus.left ? bit_rev(bus.a) : bus.a;
        s1_mask = ~(ONES >> bus.b);
        s1_fill = !bus.rotate && !bus.left && bus.arith && bus.a[WIDTH-1];
        s1_sla  = !bus.rotate && bus.left && bus.arith;
    end

    always_comb begin
        s2_x = rot_right(x1, amt1, int'(SHW) - 1, int'(LO));
    end

    // S3: bit 0 of the reversed word is the SLA sign slot; bits 1..b of the reversed
    // operand land in r[0] and the masked region, so ov/c read straight off r.
    always_comb begin
        s3_r  = rot_right(x2, amt2, int'(LO) - 1, 0);
        s3_sh = rot2 ? s3_r : ((s3_r & ~m2) | ({WIDTH{fill2}} & m2));
        if (sla2) s3_sh[0] = msb2;
        s3_res = left2 ? bit_rev(s3_sh) : s3_sh;
        s3_ov  = sla2 && (|((s3_r ^ {WIDTH{msb2}}) & (m2 | WIDTH'(1))));
        s3_c   = s3_r[WIDTH-1] & m2[WIDTH-1];
        s3_z   = (s3_res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            x1    <= '0;
            m1    <= '0;
            amt1  <= '0;
            rot1  <= 1'b0;
            left1 <= 1'b0;
            sla1  <= 1'b0;
            fill1 <= 1'b0;
            msb1  <= 1'b0;
            x2    <= '0;
            m2    <= '0;
            amt2  <= '0;
            rot2  <= 1'b0;
            left2 <= 1'b0;
            sla2  <= 1'b0;
            fill2 <= 1'b0;
            msb2  <= 1'b0;
            q_r   <= '0;
            ov_r  <= 1'b0;
            z_r   <= 1'b0;
            c_r   <= 1'b0;
        end else begin
            if (in_rdy) v1 <= bus.in_valid;
            if (adv1)   v2 <= v1;
            if (adv2)   v3 <= v2;

            if (bus.in_valid && in_rdy) begin
                x1    <= s1_x;
                m1    <= s1_mask;
                amt1  <= bus.b;
                rot1  <= bus.rotate;
                left1 <= bus.left;
                sla1  <= s1_sla;
                fill1 <= s1_fill;
                msb1  <= bus.a[WIDTH-1];
            end

            if (v1 && adv1) begin
                x2    <= s2_x;
                m2    <= m1;
                amt2  <= amt1;
                rot2  <= rot1;
                left2 <= left1;
                sla2  <= sla1;
                fill2 <= fill1;
                msb2  <= msb1;
            end

            if (v2 && adv2) begin
                q_r  <= s3_res;
                ov_r <= s3_ov;
                z_r  <= s3_z;
                c_r  <= s3_c;
            end
        end
    end
endmodule
